dyn_trunc_select_gen: RTL and testbench

Pipelined operand conditioner directly upstream of the dynamic-truncation mux in the approximate PE datapath.
- Accepts BW-bit operands over a valid/ready stream and locates each operand's leading one.
- Clamps that position into the truncation window.
- Emits the operand together with its aligned select code, so the truncation stage can take in_a/select straight from out_a/out_select.

---
 rtl/dyn_trunc_select_gen_pkg.sv | 38 +++
 rtl/dyn_trunc_select_gen_lod.sv | 33 +++
 rtl/dyn_trunc_select_gen.sv | 140 ++++++++++++++
 tb/tb_dyn_trunc_select_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_trunc_select_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dyn_trunc_pkg
//  Description : Shared constants and helpers for the dynamic-truncation
//                datapath. The select-range clamp lives here so that the
//                conditioner and the truncation mux agree on which select
//                codes are legal.
//  Revision    : 1.0  initial release
// ============================================================================
package dyn_trunc_pkg;

  // Default operand width and truncation window (window = MULT_DW+1 bits).
  localparam int DEF_BW      = 16;
  localparam int DEF_MULT_DW = 6;

  // Width of a select code able to index any bit of a BW-bit operand.
  // A 1-bit operand still needs a 1-bit code.
  function automatic int sel_width(input int bw);
    if (bw <= 2) begin
      return 1;
    end
    return $clog2(bw);
  endfunction

  // Map a leading-one index into the legal select window [mult_dw, BW-1].
  // Operands whose leading one sits below the window (or that are zero)
  // use the narrowest window, which starts at mult_dw.
  function automatic int unsigned clamp_select(input int unsigned p,
                                               input logic        zero,
                                               input int unsigned mult_dw);
    if (zero || (p < mult_dw)) begin
      return mult_dw;
    end
    return p;
  endfunction

endpackage : dyn_trunc_pkg
`default_nettype wire

// File: rtl/dyn_trunc_select_gen_lod.sv
`default_nettype none
// ============================================================================
//  Module      : leading_one_detector
//  Description : Purely combinational leading-one detector. Reports the
//                index of the highest set bit of vec and flags an all-zero
//                vector (index reads 0 in that case).
//  Revision    : 1.0  initial release
// ============================================================================
module leading_one_detector
  import dyn_trunc_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int SEL_W = sel_width(BW)
) (
  input  logic [BW-1:0]    vec,
  output logic [SEL_W-1:0] idx,
  output logic             zero
);

  // Scan from LSB to MSB; the last set bit seen is the leading one.
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < BW; i++) begin
      if (vec[i]) begin
        idx  = SEL_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule : leading_one_detector
`default_nettype wire

// File: rtl/dyn_trunc_select_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dyn_trunc_select_gen
//  Description : Two-stage valid/ready operand conditioner in front of the
//                dynamic-truncation mux. S1 registers the operand (and its
//                magnitude/sign when signed input is enabled); S2 finds the
//                leading one, clamps it into the truncation window and
//                registers operand, select code and zero flag.
//  Options     : SIGNED_IN_EN - treat in_a as two's complement; out_a then
//                carries |in_a| and out_sign the original sign. Without it
//                in_a is unsigned and out_sign is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module dyn_trunc_select_gen
  import dyn_trunc_pkg::*;
#(
  parameter int BW      = DEF_BW,
  parameter int MULT_DW = DEF_MULT_DW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BW-1:0]             in_a,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BW-1:0]             out_a,
  output logic [sel_width(BW)-1:0]  out_select,
  output logic                      out_zero,
  output logic                      out_sign
);

  localparam int SEL_W = sel_width(BW);

  // --------------------------------------------------------------------------
  // Handshake: each stage may load when it is empty or its contents leave
  // this cycle. in_ready therefore depends only on state and out_ready.
  // --------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // --------------------------------------------------------------------------
  // Input magnitude. In signed mode the most negative value negates to
  // itself, which read as unsigned is exactly 2^(BW-1) - the right answer.
  // --------------------------------------------------------------------------
  logic [BW-1:0] in_mag;
  logic [BW-1:0] s1_mag;

`ifdef SIGNED_IN_EN
  logic in_sign;
  logic s1_sign;

  assign in_sign = in_a[BW-1];
  assign in_mag  = in_sign ? (~in_a + BW'(1)) : in_a;
`else
  assign in_mag  = in_a;
`endif

  // S1: capture operand magnitude (and sign) on an accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag <= in_mag;
      end
    end
  end

`ifdef SIGNED_IN_EN
  // S1 sign register, loaded alongside the magnitude.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
    end else if (s1_adv && in_valid) begin
      s1_sign <= in_sign;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // S2 combinational: leading one of the S1 magnitude, clamped to window.
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] lod_idx;
  logic             lod_zero;
  logic [SEL_W-1:0] sel_next;

  leading_one_detector #(
    .BW    (BW),
    .SEL_W (SEL_W)
  ) u_lod (
    .vec  (s1_mag),
    .idx  (lod_idx),
    .zero (lod_zero)
  );

  assign sel_next = SEL_W'(clamp_select(32'(lod_idx), lod_zero,
                                        unsigned'(MULT_DW)));

  // S2: register outputs; they hold while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_a      <= '0;
      out_select <= SEL_W'(MULT_DW);
      out_zero   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_a      <= s1_mag;
        out_select <= sel_next;
        out_zero   <= lod_zero;
      end
    end
  end

`ifdef SIGNED_IN_EN
  // S2 sign register, travelling with the operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sign <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_sign <= s1_sign;
    end
  end
`else
  assign out_sign = 1'b0;
`endif

endmodule : dyn_trunc_select_gen
`default_nettype wire

// File: tb/tb_dyn_trunc_select_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dyn_trunc_select_gen
//  Description : Self-checking bench for dyn_trunc_select_gen (BW=16,
//                MULT_DW=6): directed table, latency/backpressure/reset
//                sequences and randomized traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dyn_trunc_select_gen;

  localparam int BW      = 16;
  localparam int MULT_DW = 6;
  localparam int SEL_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    in_a = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BW-1:0]    out_a;
  logic [SEL_W-1:0] out_select;
  logic             out_zero;
  logic             out_sign;

  dyn_trunc_select_gen #(.BW(BW), .MULT_DW(MULT_DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_select (out_select),
    .out_zero   (out_zero),
    .out_sign   (out_sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] ea;
    int          esel;
    logic        ezero;
    logic        esign;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  int          checks = 0;
  int          errors = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_a;
  logic [3:0]  prev_sel;
  logic        last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: magnitude, floor(log2), then clamp into [MULT_DW, BW-1].
  function automatic exp_t model(input logic [15:0] a);
    exp_t        e;
    int unsigned mag;
    int unsigned tmp;
    int          p;
    e.a     = a;
    mag     = a;
    e.esign = 1'b0;
`ifdef SIGNED_IN_EN
    if (a >= 16'h8000) begin
      mag     = 65536 - int'(a);
      e.esign = 1'b1;
    end
`endif
    e.ea    = mag[15:0];
    e.ezero = (mag == 0);
    p   = -1;
    tmp = mag;
    while (tmp != 0) begin
      tmp = tmp / 2;
      p++;
    end
    e.esel = (p < MULT_DW) ? MULT_DW : p;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] a, input int sel, input logic z);
    exp_t e;
    e.a     = a;
    e.ea    = a;
    e.esel  = sel;
    e.ezero = z;
`ifdef SIGNED_IN_EN
    e.esign = a[15];
`else
    e.esign = 1'b0;
`endif
    return e;
  endfunction

  task automatic drive(input logic v, input exp_t e);
    in_valid = v;
    in_a     = e.a;
    pend     = e;
  endtask

  // One clock: sample handshakes before the edge, score, then advance.
  task automatic tick();
    logic acc;
    logic pop;
    exp_t e;
    #1;
    acc = rst_n && in_valid && in_ready;
    pop = rst_n && out_valid && out_ready;
    if (rst_n && hold_prev) begin
      chk("hold_a", out_a, prev_a);
      chk("hold_sel", out_select, prev_sel);
    end
    hold_prev = rst_n && out_valid && !out_ready;
    prev_a    = out_a;
    prev_sel  = out_select;
    if (pop) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got out_a %0h expected no output", out_a);
      end else begin
        e = q.pop_front();
        chk("out_a", out_a, e.ea);
        chk("out_select", out_select, e.esel);
        chk("out_zero", out_zero, e.ezero);
        chk("out_sign", out_sign, e.esign);
      end
    end
    if (acc) q.push_back(pend);
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  exp_t tbl[11];

  initial begin
    tbl[0]  = mk(16'h0100, 8, 1'b0);
    tbl[1]  = mk(16'h0005, 6, 1'b0);
    tbl[2]  = mk(16'h0000, 6, 1'b1);
    tbl[3]  = mk(16'h8000, 15, 1'b0);
    tbl[4]  = mk(16'h0040, 6, 1'b0);
    tbl[5]  = mk(16'h0200, 9, 1'b0);
    tbl[6]  = mk(16'h1000, 12, 1'b0);
    tbl[7]  = mk(16'h0800, 11, 1'b0);
    tbl[8]  = mk(16'h0001, 6, 1'b0);
    tbl[9]  = mk(16'h007F, 6, 1'b0);
    tbl[10] = mk(16'h0080, 7, 1'b0);

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_select", out_select, MULT_DW);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_sign", out_sign, 0);

    // Latency: output registered two edges after presentation
    out_ready = 1'b1;
    drive(1'b1, model(16'h0100));
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_valid", out_valid, 0);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_select", out_select, 8);
    chk("lat_a", out_a, 16'h0100);
    tick();

    // Directed table, streamed back to back
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("table_throughput_left", q.size(), 0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, model(16'h0040));
    tick();
    drive(1'b1, model(16'h0200));
    tick();
    drive(1'b1, model(16'h1000));
    chk("bp_in_ready_low", in_ready, 0);
    tick();
    tick();
    tick();
    chk("bp_hold_a", out_a, 16'h0040);
    chk("bp_hold_sel", out_select, 6);
    chk("bp_queued", q.size(), 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && in_valid; k++) begin
      tick();
      if (last_acc) in_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) tick();
    chk("bp_drained", q.size(), 0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, model(16'h0100));
    tick();
    drive(1'b1, model(16'h0200));
    tick();
    in_valid = 1'b0;
    chk("rs_full_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    hold_prev = 1'b0;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_out_select", out_select, 6);
    out_ready = 1'b1;
    drive(1'b1, model(16'h0800));
    tick();
    in_valid = 1'b0;
    tick();
    chk("rs_post_valid", out_valid, 1);
    chk("rs_post_select", out_select, 11);
    tick();

`ifdef SIGNED_IN_EN
    // Signed operands
    drive(1'b1, model(16'hFF00));
    tick();
    in_valid = 1'b0;
    tick();
    chk("sg_ff00_a", out_a, 16'h0100);
    chk("sg_ff00_sign", out_sign, 1);
    chk("sg_ff00_sel", out_select, 8);
    tick();
    drive(1'b1, model(16'h8000));
    tick();
    in_valid = 1'b0;
    tick();
    chk("sg_8000_a", out_a, 16'h8000);
    chk("sg_8000_sign", out_sign, 1);
    chk("sg_8000_sel", out_select, 15);
    tick();
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [15:0] r;
      r = 16'($urandom) >> $urandom_range(0, 16);
      drive(1'($urandom_range(0, 1)), model(r));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk("rand_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_dyn_trunc_select_gen
`default_nettype wire
